// File: rtl/hpm_overflow_irq_pkg.sv
// Shared constants and types for the HPM overflow/LCOFI block.
// Holds the CSR addresses it owns, the request state encoding and a counter sizing helper.
package hpm_overflow_irq_pkg;

  localparam logic [11:0] CSR_SCOUNTOVF     = 12'hDA0;
  localparam logic [11:0] CSR_MHPM_EVENT_3  = 12'h323;
  localparam logic [11:0] CSR_MHPM_EVENT_3H = 12'h723;

  typedef enum logic [1:0] {
    HPM_IRQ_IDLE    = 2'd0,
    HPM_IRQ_PENDING = 2'd1,
    HPM_IRQ_HOLDOFF = 2'd2
  } hpm_irq_state_e;

  // A zero-length holdoff still needs a one-bit counter to keep the datapath legal.
  function automatic int unsigned hpm_cnt_width(input int unsigned holdoff);
    if (holdoff == 32'd0) begin
      return 32'd1;
    end else begin
      return $clog2(holdoff + 32'd1);
    end
  endfunction

endpackage

// File: rtl/hpm_overflow_irq_if.sv
// CSR bus shared with the HPM counter block: address, write strobe/data and OF-bit read data.
interface hpm_overflow_irq_if #(
  parameter int unsigned XLEN = 64
) ();

  logic [11:0]     addr;
  logic            we;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/hpm_overflow_irq.sv
// Sticky per-counter overflow bits with OF-bit CSR reads/writes and the LCOFI request,
// including a holdoff window after each acknowledged interrupt.
module hpm_overflow_irq
  import hpm_overflow_irq_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned NumCounters   = 6,
  parameter int unsigned HoldoffCycles = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   debug_mode_i,
  input  logic [NumCounters-1:0] incr_i,
  input  logic [NumCounters-1:0] wrap_i,
  hpm_overflow_irq_if.slave      csr_bus,
  input  logic                   irq_ack_i,
  input  logic                   lcofip_clr_i,
  output logic [NumCounters-1:0] of_o,
  output logic                   irq_o
);

  localparam int unsigned     CntW     = hpm_cnt_width(HoldoffCycles);
  localparam logic [CntW-1:0] HoldLoad = (HoldoffCycles > 32'd0) ? CntW'(HoldoffCycles - 32'd1)
                                                                 : {CntW{1'b0}};
  // RV32 keeps OF in the high half of mhpmevent, so the owned window moves to 0x723.
  localparam logic [11:0]     EvtBase  = (XLEN == 32'd64) ? CSR_MHPM_EVENT_3 : CSR_MHPM_EVENT_3H;

  logic [NumCounters-1:0] of_q, of_d;
  logic [NumCounters-1:0] ovf_s;
  logic                   new_ovf_s;
  logic                   late_eff_s;
  hpm_irq_state_e         state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   late_q, late_d;
  logic                   irq_q;
  logic [XLEN-1:0]        rdata_s;
  logic                   unused_wdata_s;

  // OF capture, CSR read/write decode and request state machine next-state.
  always_comb begin
    ovf_s      = incr_i & wrap_i & {NumCounters{~(debug_mode_i | csr_bus.we)}};
    new_ovf_s  = |(ovf_s & ~of_q);
    of_d       = of_q | ovf_s;
    rdata_s    = {XLEN{1'b0}};
    state_d    = state_q;
    cnt_d      = cnt_q;
    late_d     = late_q;
    late_eff_s = late_q & ~lcofip_clr_i;

    for (int unsigned k = 0; k < NumCounters; k++) begin
      if (csr_bus.addr == (EvtBase + 12'(k))) begin
        rdata_s[XLEN-1] = of_q[k];
        if (csr_bus.we) begin
          of_d[k] = csr_bus.wdata[XLEN-1];
        end else begin
          of_d[k] = of_q[k] | ovf_s[k];
        end
      end else begin
        rdata_s = rdata_s;
      end
    end

    if (csr_bus.addr == CSR_SCOUNTOVF) begin
      rdata_s[NumCounters+2:3] = of_q;
    end else begin
      rdata_s = rdata_s;
    end

    case (state_q)
      HPM_IRQ_IDLE: begin
        if (new_ovf_s) begin
          state_d = HPM_IRQ_PENDING;
        end else begin
          state_d = HPM_IRQ_IDLE;
        end
      end
      HPM_IRQ_PENDING: begin
        if (irq_ack_i) begin
          if (HoldoffCycles == 32'd0) begin
            state_d = new_ovf_s ? HPM_IRQ_PENDING : HPM_IRQ_IDLE;
          end else begin
            state_d = HPM_IRQ_HOLDOFF;
            cnt_d   = HoldLoad;
            late_d  = new_ovf_s;
          end
        end else if (lcofip_clr_i) begin
          state_d = HPM_IRQ_IDLE;
        end else begin
          state_d = HPM_IRQ_PENDING;
        end
      end
      HPM_IRQ_HOLDOFF: begin
        // Overflows during the window are remembered and replayed when it closes.
        if (cnt_q == {CntW{1'b0}}) begin
          state_d = (late_eff_s | new_ovf_s) ? HPM_IRQ_PENDING : HPM_IRQ_IDLE;
          late_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q - {{(CntW-1){1'b0}}, 1'b1};
          late_d = late_eff_s | new_ovf_s;
        end
      end
      default: begin
        state_d = HPM_IRQ_IDLE;
        cnt_d   = {CntW{1'b0}};
        late_d  = 1'b0;
      end
    endcase
  end

  // State, OF bits and registered interrupt request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      of_q    <= {NumCounters{1'b0}};
      state_q <= HPM_IRQ_IDLE;
      cnt_q   <= {CntW{1'b0}};
      late_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      of_q    <= of_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      late_q  <= late_d;
      irq_q   <= (state_d == HPM_IRQ_PENDING);
    end
  end

  assign unused_wdata_s = ^csr_bus.wdata[XLEN-2:0];
  assign csr_bus.rdata  = rdata_s;
  assign of_o           = of_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_hpm_overflow_irq.sv
// Bench for hpm_overflow_irq: directed scenarios plus randomized traffic against a
// cycle-level behavioural model (RV64 instance) and directed RV32 layout checks.
module tb_hpm_overflow_irq;

  localparam int N    = 6;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] incr64, wrap64, of64, incr32, wrap32, of32;
  logic dbg64, ack64, clr64, irq64, dbg32, ack32, clr32, irq32;

  hpm_overflow_irq_if #(.XLEN(64)) if64 ();
  hpm_overflow_irq_if #(.XLEN(32)) if32 ();

  hpm_overflow_irq #(.XLEN(64), .NumCounters(N), .HoldoffCycles(HOLD)) u64 (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg64), .incr_i(incr64), .wrap_i(wrap64),
    .csr_bus(if64.slave), .irq_ack_i(ack64), .lcofip_clr_i(clr64), .of_o(of64), .irq_o(irq64));

  hpm_overflow_irq #(.XLEN(32), .NumCounters(N), .HoldoffCycles(HOLD)) u32 (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg32), .incr_i(incr32), .wrap_i(wrap32),
    .csr_bus(if32.slave), .irq_ack_i(ack32), .lcofip_clr_i(clr32), .of_o(of32), .irq_o(irq32));

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: OF bits, a pending flag, remaining holdoff cycles and a late flag.
  bit [N-1:0] m_of;
  bit m_pend;
  int m_hold;
  bit m_late;

  function automatic logic [63:0] mdl_read(input logic [11:0] a);
    logic [63:0] r;
    r = 64'd0;
    if (a >= 12'h323 && a <= 12'h328) r[63] = m_of[a - 12'h323];
    else if (a == 12'hDA0) for (int k = 0; k < N; k++) r[3+k] = m_of[k];
    return r;
  endfunction

  task automatic mdl_step();
    bit [N-1:0] ovf;
    bit fresh, late;
    if (!rst_n) begin
      m_of = '0; m_pend = 1'b0; m_hold = 0; m_late = 1'b0;
    end else begin
      ovf = (dbg64 || if64.we) ? '0 : (incr64 & wrap64);
      fresh = (ovf & ~m_of) != '0;
      m_of = m_of | ovf;
      if (if64.we && if64.addr >= 12'h323 && if64.addr <= 12'h328)
        m_of[if64.addr - 12'h323] = if64.wdata[63];
      if (m_pend) begin
        if (ack64) begin m_pend = 1'b0; m_hold = HOLD; m_late = fresh; end
        else if (clr64) m_pend = 1'b0;
      end else if (m_hold > 0) begin
        late = (m_late && !clr64) || fresh;
        m_hold--;
        if (m_hold == 0) begin m_pend = late; m_late = 1'b0; end
        else m_late = late;
      end else begin
        m_pend = fresh;
      end
    end
  endtask

  // One clock on the RV64 instance, checked against the model before and after the edge.
  task automatic step64(input string tag);
    logic [63:0] exp_rd;
    #1;
    exp_rd = mdl_read(if64.addr);
    n_chk++;
    if (if64.rdata !== exp_rd) begin
      n_err++;
      $display("FAIL %s rdata addr=%h: got %h expected %h", tag, if64.addr, if64.rdata, exp_rd);
    end
    mdl_step();
    @(posedge clk); #1;
    n_chk++;
    if (of64 !== m_of || irq64 !== m_pend) begin
      n_err++;
      $display("FAIL %s state: got of=%b irq=%b expected of=%b irq=%b", tag, of64, irq64, m_of, m_pend);
    end
  endtask

  task automatic idle64();
    incr64 = '0; wrap64 = '0; dbg64 = 1'b0; ack64 = 1'b0; clr64 = 1'b0;
    if64.we = 1'b0; if64.addr = 12'h000; if64.wdata = 64'd0;
  endtask

  task automatic idle32();
    incr32 = '0; wrap32 = '0; dbg32 = 1'b0; ack32 = 1'b0; clr32 = 1'b0;
    if32.we = 1'b0; if32.addr = 12'h000; if32.wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    incr64 = '1; wrap64 = '1; incr32 = '1; wrap32 = '1;
    for (int i = 0; i < 2; i++) begin
      step64("reset_hold");
      n_chk++;
      if (of64 !== 6'h00 || irq64 !== 1'b0 || of32 !== 6'h00 || irq32 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: got of64=%b irq64=%b of32=%b irq32=%b expected zeros", of64, irq64, of32, irq32);
      end
    end
    rst_n = 1'b1;
    step64("reset_release");
    n_chk++;
    if (of64 !== 6'h3F || irq64 !== 1'b1 || of32 !== 6'h3F || irq32 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got of64=%b irq64=%b of32=%b irq32=%b expected all-ones, irq=1", of64, irq64, of32, irq32);
    end
    idle64(); idle32();
  endtask

  task automatic test_single_overflow();
    rst_n = 1'b0; step64("re_reset"); rst_n = 1'b1;
    incr64 = 6'b000100; wrap64 = 6'b000100;
    step64("ovf2");
    idle64();
    n_chk++;
    if (of64 !== 6'b000100 || irq64 !== 1'b1) begin
      n_err++; $display("FAIL ovf2: got of=%b irq=%b expected of=000100 irq=1", of64, irq64);
    end
    if64.addr = 12'hDA0; #1;
    n_chk++;
    if (if64.rdata !== 64'h20) begin
      n_err++; $display("FAIL scountovf: got %h expected %h", if64.rdata, 64'h20);
    end
    if64.addr = 12'h325; #1;
    n_chk++;
    if (if64.rdata !== 64'h8000_0000_0000_0000) begin
      n_err++; $display("FAIL mhpmevent5: got %h expected %h", if64.rdata, 64'h8000_0000_0000_0000);
    end
    if64.addr = 12'h329; #1;
    n_chk++;
    if (if64.rdata !== 64'd0) begin
      n_err++; $display("FAIL non_owned: got %h expected 0", if64.rdata);
    end
    if64.addr = 12'h000;
  endtask

  task automatic test_holdoff();
    logic [4:0] exp_irq;
    exp_irq = 5'b10000;
    ack64 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step64("holdoff_late");
      ack64 = 1'b0; incr64 = '0; wrap64 = '0;
      if (i == 1) begin incr64 = 6'b000001; wrap64 = 6'b000001; end
      n_chk++;
      if (irq64 !== exp_irq[i]) begin
        n_err++; $display("FAIL holdoff_late t+%0d: got irq=%b expected %b", i + 1, irq64, exp_irq[i]);
      end
    end
    idle64();
    clr64 = 1'b1; step64("clr_pending"); clr64 = 1'b0;
    n_chk++;
    if (irq64 !== 1'b0) begin
      n_err++; $display("FAIL clr_pending: got irq=%b expected 0", irq64);
    end
    incr64 = 6'b000010; wrap64 = 6'b000010; step64("ovf1"); idle64();
    ack64 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step64("holdoff_quiet");
      ack64 = 1'b0;
      n_chk++;
      if (irq64 !== 1'b0) begin
        n_err++; $display("FAIL holdoff_quiet t+%0d: got irq=%b expected 0", i + 1, irq64);
      end
    end
  endtask

  task automatic test_write_suppress();
    if64.we = 1'b1; if64.addr = 12'h323; if64.wdata = 64'h7FFF_FFFF_FFFF_FFFF;
    incr64 = 6'b000001; wrap64 = 6'b000001;
    step64("write_suppress");
    idle64();
    n_chk++;
    if (of64[0] !== 1'b0 || irq64 !== 1'b0) begin
      n_err++; $display("FAIL write_suppress: got of0=%b irq=%b expected of0=0 irq=0", of64[0], irq64);
    end
  endtask

  task automatic test_reoverflow();
    incr64 = 6'b000010; wrap64 = 6'b000010;
    step64("reovf1"); idle64();
    n_chk++;
    if (irq64 !== 1'b0 || of64[1] !== 1'b1) begin
      n_err++; $display("FAIL reovf1: got irq=%b of1=%b expected irq=0 of1=1", irq64, of64[1]);
    end
    incr64 = 6'b000011; wrap64 = 6'b000011;
    step64("reovf0"); idle64();
    n_chk++;
    if (irq64 !== 1'b1) begin
      n_err++; $display("FAIL reovf0: got irq=%b expected 1", irq64);
    end
  endtask

  task automatic test_random();
    logic [11:0] addrs [8];
    addrs = '{12'h323, 12'h324, 12'h325, 12'h326, 12'h327, 12'h328, 12'h329, 12'hDA0};
    for (int i = 0; i < 400; i++) begin
      incr64 = N'($urandom);
      wrap64 = N'($urandom & $urandom & $urandom);
      dbg64  = ($urandom_range(7) == 0);
      ack64  = ($urandom_range(4) == 0);
      clr64  = ($urandom_range(7) == 0);
      if64.we    = ($urandom_range(7) == 0);
      if64.addr  = addrs[$urandom_range(7)];
      if64.wdata = {$urandom, $urandom};
      step64("random");
    end
    idle64();
  endtask

  task automatic tick32(input string tag, input logic [N-1:0] exp_of, input logic exp_irq);
    @(posedge clk); #1;
    n_chk++;
    if (of32 !== exp_of || irq32 !== exp_irq) begin
      n_err++; $display("FAIL %s: got of=%b irq=%b expected of=%b irq=%b", tag, of32, irq32, exp_of, exp_irq);
    end
  endtask

  task automatic read32(input string tag, input logic [11:0] a, input logic [31:0] exp);
    if32.addr = a; #1;
    n_chk++;
    if (if32.rdata !== exp) begin
      n_err++; $display("FAIL %s: got %h expected %h", tag, if32.rdata, exp);
    end
  endtask

  task automatic test_rv32();
    idle32();
    rst_n = 1'b0; tick32("rv32_reset", 6'b000000, 1'b0); rst_n = 1'b1;
    if32.we = 1'b1; if32.addr = 12'h724; if32.wdata = 32'h8000_0000;
    tick32("rv32_sw_set", 6'b000010, 1'b0);
    if32.we = 1'b0;
    read32("rv32_evt4h", 12'h724, 32'h8000_0000);
    read32("rv32_scountovf", 12'hDA0, 32'h0000_0010);
    read32("rv32_evt4_low", 12'h324, 32'h0000_0000);
    if32.we = 1'b1; if32.addr = 12'h324; if32.wdata = 32'hFFFF_FFFF;
    tick32("rv32_low_write", 6'b000010, 1'b0);
    if32.addr = 12'h724; if32.wdata = 32'h7FFF_FFFF;
    tick32("rv32_sw_clear", 6'b000000, 1'b0);
    if32.we = 1'b0;
    incr32 = 6'b001000; wrap32 = 6'b001000; dbg32 = 1'b1;
    tick32("rv32_debug", 6'b000000, 1'b0);
    dbg32 = 1'b0;
    tick32("rv32_ovf3", 6'b001000, 1'b1);
    idle32();
    read32("rv32_evt6h", 12'h726, 32'h8000_0000);
  endtask

  initial begin
    rst_n = 1'b0;
    idle64(); idle32();
    m_of = '0; m_pend = 1'b0; m_hold = 0; m_late = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single_overflow();
    test_holdoff();
    test_write_suppress();
    test_reoverflow();
    test_random();
    test_rv32();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
